// File: rtl/alu_resp_unit.sv
// ALU responder: accepts (a, b, op) requests, queues (z, zero flag) in a small FIFO
// and returns them in order. Define ALU_RESP_ERR_EN to add a per-entry resp_err output.
module alu_resp_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_z,
  output logic             resp_ex,
`ifdef ALU_RESP_ERR_EN
  output logic             resp_err,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  logic [WIDTH-1:0] alu_z;
  logic             alu_ex;
  logic             push, pop;

  logic [WIDTH-1:0] z_mem_q  [DEPTH];
  logic [WIDTH-1:0] z_mem_d  [DEPTH];
  logic             ex_mem_q [DEPTH];
  logic             ex_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  // NOTE: every variable gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    alu_z = '0;
    case (op_e'(req_op))
      OP_AND:  alu_z = req_a & req_b;
      OP_OR:   alu_z = req_a | req_b;
      OP_ADD:  alu_z = req_a + req_b;
      OP_SUB:  alu_z = req_a + ~req_b + WIDTH'(1);
      OP_SLT:  alu_z = ($signed(req_a) < $signed(req_b)) ? WIDTH'(1) : '0;
      default: alu_z = '0;
    endcase
  end

  assign alu_ex = (alu_z == '0);

  assign req_ready  = (count_q != FULL);
  assign resp_valid = (count_q != '0);
  assign push       = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    z_mem_d    = z_mem_q;
    ex_mem_d   = ex_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    done_cnt_d = done_cnt_q;
    if (push) begin
      z_mem_d[wr_ptr_q]  = alu_z;
      ex_mem_d[wr_ptr_q] = alu_ex;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage is reset too, because resp_z/resp_ex must read 0 out of
  // reset and they are taken straight from the head entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        z_mem_q[i]  <= '0;
        ex_mem_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      z_mem_q    <= z_mem_d;
      ex_mem_q   <= ex_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign resp_z   = z_mem_q[rd_ptr_q];
  assign resp_ex  = ex_mem_q[rd_ptr_q];
  assign done_cnt = done_cnt_q;

`ifdef ALU_RESP_ERR_EN
  logic alu_err;
  logic err_mem_q [DEPTH];
  logic err_mem_d [DEPTH];

  assign alu_err = !(req_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT});

  always_comb begin
    err_mem_d = err_mem_q;
    if (push) err_mem_d[wr_ptr_q] = alu_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) err_mem_q[i] <= 1'b0;
    end else begin
      err_mem_q <= err_mem_d;
    end
  end

  assign resp_err = err_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_alu_resp_unit.sv
// Scoreboard bench for alu_resp_unit: the driver pushes expected responses on accept,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_resp_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_z;
  logic             resp_ex;
`ifdef ALU_RESP_ERR_EN
  logic             resp_err;
`endif
  logic [CNT_W-1:0] done_cnt;

  alu_resp_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_z     (resp_z),
    .resp_ex    (resp_ex),
`ifdef ALU_RESP_ERR_EN
    .resp_err   (resp_err),
`endif
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] z;
    logic             ex;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_done = 0;
  int   cyc      = 0;
  bit   stream_on = 0;
  int   stream_pops = 0;
  int   stream_gaps = 0;
  int   last_pop_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [WIDTH-1:0] ref_z(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op);
    return !(op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, b, input logic [2:0] op,
                       input logic [WIDTH-1:0] exp_z, output int waits);
    logic accepted;
    exp_t e;
    accepted  = 1'b0;
    waits     = 0;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.z   = exp_z;
        e.ex  = (exp_z == '0);
        e.err = ref_err(op);
        sb.push_back(e);
        accepted = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: a handshake seen at negedge completes on the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("resp_z", 64'(resp_z), 64'(e.z));
          check("resp_ex", 64'(resp_ex), 64'(e.ex));
`ifdef ALU_RESP_ERR_EN
          check("resp_err", 64'(resp_err), 64'(e.err));
`endif
        end
        exp_done++;
        if (stream_on) begin
          if (stream_pops > 0 && cyc != last_pop_cyc + 1) stream_gaps++;
          stream_pops++;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  logic [2:0] op_tab [6];
  int waits, total_waits;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0] rop;

  initial begin
    op_tab[0] = 3'b000; op_tab[1] = 3'b001; op_tab[2] = 3'b010;
    op_tab[3] = 3'b110; op_tab[4] = 3'b111; op_tab[5] = 3'b011;
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;

    #12;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_z", 64'(resp_z), 64'd0);
    check("rst_resp_ex", 64'(resp_ex), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single add and one-cycle latency
    resp_ready = 1'b1;
    issue(32'd5, 32'd7, 3'b010, 32'd12, waits);
    check("add_latency_valid", 64'(resp_valid), 64'd1);
    drain();
    check("done_after_add", 64'(done_cnt), 64'(exp_done));
    check("done_is_1", 64'(done_cnt), 64'd1);

    // Subtract to zero, signed SLT, unsupported ops
    issue(32'h8000_0000, 32'h8000_0000, 3'b110, 32'd0, waits);
    issue(32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, waits);
    issue(32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0, waits);
    issue(32'd3, 32'd4, 3'b011, 32'd0, waits);
    issue(32'd3, 32'd4, 3'b101, 32'd0, waits);
    drain();

    // Back-pressure
    resp_ready = 1'b0;
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, waits);
    issue(32'h1, 32'h2, 3'b001, 32'h3, waits);
    check("bp_req_ready_full", 64'(req_ready), 64'd0);
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_head_stable", 64'(resp_z), 64'hF000_F000);
    fork
      issue(32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, waits);
      begin @(posedge clk); #1; resp_ready = 1'b1; end
    join
    check("bp_third_waits", 64'(waits), 64'd2);
    drain();
    check("bp_done", 64'(done_cnt), 64'(exp_done));

    // Streaming: 20 back-to-back requests
    stream_on = 1;
    total_waits = 0;
    for (int i = 0; i < 20; i++) begin
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      rop = op_tab[$urandom_range(0, 5)];
      issue(ra, rb, rop, ref_z(ra, rb, rop), waits);
      total_waits += waits;
    end
    drain();
    stream_on = 0;
    check("stream_waits", 64'(total_waits), 64'd0);
    check("stream_pops", 64'(stream_pops), 64'd20);
    check("stream_gaps", 64'(stream_gaps), 64'd0);
    check("stream_done", 64'(done_cnt), 64'(exp_done));

    // Reset mid-operation with two entries queued
    resp_ready = 1'b0;
    issue(32'd9, 32'd9, 3'b010, 32'd18, waits);
    issue(32'd4, 32'd4, 3'b110, 32'd0, waits);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_done_cnt", 64'(done_cnt), 64'd0);
    check("midrst_resp_z", 64'(resp_z), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    sb.delete();
    exp_done = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    resp_ready = 1'b1;
    issue(32'd1, 32'd1, 3'b010, 32'd2, waits);
    drain();
    check("post_rst_done", 64'(done_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
